// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
package div_pkg;

  localparam int DIV_ITER = 32;

  typedef enum logic [1:0] {
    IDLE,
    DIVZERO,
    ON,
    END
  } div_state_t;

endpackage

// File: rtl/div_abs.sv
// Conditional two's-complement negate; wraps, so the most negative value maps to itself.
module div_abs #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] val_o
);

  assign val_o = neg_i ? (~val_i + {{(WIDTH-1){1'b0}}, 1'b1}) : val_i;

endmodule

// File: rtl/div_iter.sv
// Radix-2 restoring divider, one quotient bit per cycle, result packed as {remainder, quotient}.
// state   | meaning
// IDLE    | waiting for start_i; operands latched on accept
// DIVZERO | divisor was zero; result forced to 0
// ON      | one restoring step per cycle, WIDTH steps
// END     | sign fix-up, register result, pulse ready_o
module div_iter
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_ITER
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_div_i,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  div_state_t         state_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   dvd_q;
  logic [WIDTH-1:0]   dvs_q;
  logic [WIDTH-1:0]   rem_q;
  logic               neg_quo_q;
  logic               neg_rem_q;
  logic               ready_q;
  logic [2*WIDTH-1:0] result_q;

  logic [WIDTH-1:0]   op1_abs;
  logic [WIDTH-1:0]   op2_abs;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   rem_sub;
  logic [WIDTH-1:0]   rem_d;
  logic [WIDTH-1:0]   dvd_d;
  logic               quo_bit;
  logic               abort;

  div_abs #(.WIDTH(WIDTH)) u_abs_op1 (
    .val_i (opdata1_i),
    .neg_i (signed_div_i & opdata1_i[WIDTH-1]),
    .val_o (op1_abs)
  );

  div_abs #(.WIDTH(WIDTH)) u_abs_op2 (
    .val_i (opdata2_i),
    .neg_i (signed_div_i & opdata2_i[WIDTH-1]),
    .val_o (op2_abs)
  );

  div_abs #(.WIDTH(WIDTH)) u_fix_quo (
    .val_i (dvd_q),
    .neg_i (neg_quo_q),
    .val_o (quo_fix)
  );

  div_abs #(.WIDTH(WIDTH)) u_fix_rem (
    .val_i (rem_q),
    .neg_i (neg_rem_q),
    .val_o (rem_fix)
  );

  assign abort = flush | annul_i;

  // dvd_q shifts out dividend bits at the top and collects quotient bits at the bottom
  assign rem_sh  = {rem_q, dvd_q[WIDTH-1]};
  assign quo_bit = (rem_sh >= {1'b0, dvs_q});
  assign rem_sub = rem_sh[WIDTH-1:0] - dvs_q;
  assign rem_d   = quo_bit ? rem_sub : rem_sh[WIDTH-1:0];
  assign dvd_d   = {dvd_q[WIDTH-2:0], quo_bit};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      ready_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      ready_q <= 1'b0;
      if (abort) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_i) begin
              dvd_q     <= op1_abs;
              dvs_q     <= op2_abs;
              neg_quo_q <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
              neg_rem_q <= signed_div_i & opdata1_i[WIDTH-1];
              cnt_q     <= '0;
              rem_q     <= '0;
              state_q   <= (opdata2_i == '0) ? DIVZERO : ON;
            end
          end
          DIVZERO: begin
            dvd_q   <= '0;
            rem_q   <= '0;
            state_q <= END;
          end
          ON: begin
            dvd_q <= dvd_d;
            rem_q <= rem_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) state_q <= END;
          end
          END: begin
            result_q <= {rem_fix, quo_fix};
            ready_q  <= 1'b1;
            state_q  <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign ready_o  = ready_q;
  assign result_o = result_q;

endmodule
